// File: rtl/fp_minmax_pipe_pkg.sv
// Shared FP_Unit definitions: operand class encodings, min/max op codes and
// a canonical quiet-NaN generator usable for any exponent/mantissa split.
// Imported by fp_classify, fp_minmax_pipe and their benches.
package fp_unit_pkg;

  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_SUB  = 3'd1,
    CLS_NORM = 3'd2,
    CLS_INF  = 3'd3,
    CLS_QNAN = 3'd4,
    CLS_SNAN = 3'd5
  } fp_cls_e;

  localparam logic OP_MIN = 1'b0;
  localparam logic OP_MAX = 1'b1;

  // Widest format the NaN generator supports; callers slice down to width.
  localparam int MAX_FP_WIDTH = 128;

  // Canonical qNaN: sign 0, exponent all ones, fraction MSB set, rest zero.
  function automatic logic [MAX_FP_WIDTH-1:0] canon_qnan(input int exp_w, input int man_w);
    logic [MAX_FP_WIDTH-1:0] one;
    logic [MAX_FP_WIDTH-1:0] r;
    one    = '0;
    one[0] = 1'b1;
    r      = ((one << exp_w) - one) << man_w;
    r      = r | (one << (man_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/fp_minmax_pipe_if.sv
// Handshake and data bundle for fp_minmax_pipe.
// Ports: in_valid/in_ready/in_ctrl_minmax/in_numA/in_numB/in_tag (request),
//        out_valid/out_ready/out_num/out_tag/out_nv (result).
interface fp_minmax_pipe_if #(
  parameter int EXP_WIDTH = 11,
  parameter int MAN_WIDTH = 52,
  parameter int TAG_WIDTH = 4
);
  localparam int DATA_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH;

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_ctrl_minmax;
  logic [DATA_WIDTH-1:0] in_numA;
  logic [DATA_WIDTH-1:0] in_numB;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_num;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic                  out_nv;

  // Requester / result consumer side.
  modport master (
    output in_valid, in_ctrl_minmax, in_numA, in_numB, in_tag, out_ready,
    input  in_ready, out_valid, out_num, out_tag, out_nv
  );

  // The min/max unit itself.
  modport slave (
    input  in_valid, in_ctrl_minmax, in_numA, in_numB, in_tag, out_ready,
    output in_ready, out_valid, out_num, out_tag, out_nv
  );
endinterface

// File: rtl/fp_minmax_pipe_classify.sv
// fp_classify: combinational class decode and total-order key for one operand.
// Ports: num_i (operand), cls_o (fp_cls_e class), key_o (unsigned ordering key).
// Key: positives map to {1,mag}, negatives to {0,~mag}, so -0 < +0 and
// -inf < finite < +inf under plain unsigned compare.
module fp_classify
  import fp_unit_pkg::*;
#(
  parameter  int EXP_WIDTH = 11,
  parameter  int MAN_WIDTH = 52,
  localparam int DW        = 1 + EXP_WIDTH + MAN_WIDTH
) (
  input  logic [DW-1:0] num_i,
  output fp_cls_e       cls_o,
  output logic [DW-1:0] key_o
);

  logic [EXP_WIDTH-1:0] exp_f;
  logic [MAN_WIDTH-1:0] man_f;

  assign exp_f = num_i[DW-2 -: EXP_WIDTH];
  assign man_f = num_i[MAN_WIDTH-1:0];

  always_comb begin
    cls_o = CLS_NORM;
    if (exp_f == '0) begin
      cls_o = (man_f == '0) ? CLS_ZERO : CLS_SUB;
    end else if (&exp_f) begin
      if (man_f == '0)              cls_o = CLS_INF;
      else if (man_f[MAN_WIDTH-1])  cls_o = CLS_QNAN;
      else                          cls_o = CLS_SNAN;
    end
  end

  assign key_o = num_i[DW-1] ? {1'b0, ~num_i[DW-2:0]} : {1'b1, num_i[DW-2:0]};

endmodule

// File: rtl/fp_minmax_pipe.sv
// fp_minmax_pipe: two-stage IEEE-754 min/max with NaN and signed-zero handling.
// Ports: in_clk, in_rst (sync, active high), io (fp_minmax_pipe_if.slave).
// Latency 2, throughput 1/cycle; stages stall under out_ready=0 with stable outputs.
// Optional macro FP_MINMAX_NV_FLAG_EN: out_nv flags any sNaN operand; otherwise 0.
module fp_minmax_pipe
  import fp_unit_pkg::*;
#(
  parameter  int EXP_WIDTH  = 11,
  parameter  int MAN_WIDTH  = 52,
  parameter  int TAG_WIDTH  = 4,
  localparam int DATA_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH
) (
  input logic          in_clk,
  input logic          in_rst,
  fp_minmax_pipe_if.slave io
);

  localparam logic [DATA_WIDTH-1:0] CANON_NAN =
    DATA_WIDTH'(canon_qnan(EXP_WIDTH, MAN_WIDTH));

  fp_cls_e               cls_a, cls_b;
  logic [DATA_WIDTH-1:0] key_a, key_b;

  fp_classify #(.EXP_WIDTH(EXP_WIDTH), .MAN_WIDTH(MAN_WIDTH)) u_cls_a (
    .num_i(io.in_numA), .cls_o(cls_a), .key_o(key_a)
  );
  fp_classify #(.EXP_WIDTH(EXP_WIDTH), .MAN_WIDTH(MAN_WIDTH)) u_cls_b (
    .num_i(io.in_numB), .cls_o(cls_b), .key_o(key_b)
  );

  logic                  s1_valid_q, s1_valid_d;
  logic                  s2_valid_q, s2_valid_d;
  logic                  s1_adv, s2_adv;
  logic [DATA_WIDTH-1:0] s1_a_q, s1_b_q;
  logic                  s1_op_q;
  logic [TAG_WIDTH-1:0]  s1_tag_q;
  fp_cls_e               s1_cls_a_q, s1_cls_b_q;
  logic                  s1_a_lt_b_q, s1_b_lt_a_q;
  logic [DATA_WIDTH-1:0] s2_num_q, s2_num_d;
  logic [TAG_WIDTH-1:0]  s2_tag_q;
  logic                  a_nan, b_nan;

  // A stage moves when it is empty or its successor moves this cycle.
  always_comb begin
    s2_adv     = !s2_valid_q || io.out_ready;
    s1_adv     = !s1_valid_q || s2_adv;
    s1_valid_d = s1_adv ? io.in_valid : s1_valid_q;
    s2_valid_d = s2_adv ? s1_valid_q  : s2_valid_q;
  end

  assign io.in_ready = s1_adv && !in_rst;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // S1 payload: no reset needed, qualified by s1_valid_q.
  always_ff @(posedge in_clk) begin
    if (s1_adv && io.in_valid) begin
      s1_a_q      <= io.in_numA;
      s1_b_q      <= io.in_numB;
      s1_op_q     <= io.in_ctrl_minmax;
      s1_tag_q    <= io.in_tag;
      s1_cls_a_q  <= cls_a;
      s1_cls_b_q  <= cls_b;
      s1_a_lt_b_q <= key_a < key_b;
      s1_b_lt_a_q <= key_b < key_a;
    end
  end

  // Selection; equal keys fall through to A.
  always_comb begin
    a_nan    = (s1_cls_a_q == CLS_QNAN) || (s1_cls_a_q == CLS_SNAN);
    b_nan    = (s1_cls_b_q == CLS_QNAN) || (s1_cls_b_q == CLS_SNAN);
    s2_num_d = s1_a_q;
    if (a_nan && b_nan)        s2_num_d = CANON_NAN;
    else if (a_nan)            s2_num_d = s1_b_q;
    else if (b_nan)            s2_num_d = s1_a_q;
    else if (s1_op_q == OP_MAX) s2_num_d = s1_a_lt_b_q ? s1_b_q : s1_a_q;
    else                       s2_num_d = s1_b_lt_a_q ? s1_b_q : s1_a_q;
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      s2_num_q <= '0;
      s2_tag_q <= '0;
    end else if (s2_adv && s1_valid_q) begin
      s2_num_q <= s2_num_d;
      s2_tag_q <= s1_tag_q;
    end
  end

  assign io.out_valid = s2_valid_q;
  assign io.out_num   = s2_num_q;
  assign io.out_tag   = s2_tag_q;

`ifdef FP_MINMAX_NV_FLAG_EN
  logic s1_nv_q, s2_nv_q;

  always_ff @(posedge in_clk) begin
    if (s1_adv && io.in_valid) begin
      s1_nv_q <= (cls_a == CLS_SNAN) || (cls_b == CLS_SNAN);
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      s2_nv_q <= 1'b0;
    end else if (s2_adv && s1_valid_q) begin
      s2_nv_q <= s1_nv_q;
    end
  end

  assign io.out_nv = s2_nv_q;
`else
  assign io.out_nv = 1'b0;
`endif

endmodule

// File: doc/fp_minmax_pipe.md
Name: fp_minmax_pipe

Overview:
Parametrised, pipelined IEEE-754 min/max unit for the FP_Unit, replacing the single-width combinational min/max path. Handles any exponent/mantissa split (binary32 and binary64 as built configurations), with full NaN and signed-zero semantics. Accepts one operation per cycle under a valid/ready handshake with backpressure. Returns the selected operand, a pass-through tag, and an optional invalid flag.

Parameters:
EXP_WIDTH, 11, exponent field width
MAN_WIDTH, 52, mantissa (fraction) field width
TAG_WIDTH, 4, width of the opaque tag carried alongside each operation
DATA_WIDTH (localparam), 1+EXP_WIDTH+MAN_WIDTH, operand width; not overridable

Ports:
in_clk  input  1  clock; all logic on the rising edge
in_rst  input  1  synchronous, active-high reset
in_valid  input  1  operation presented
in_ready  output  1  unit can accept an operation this cycle
in_ctrl_minmax  input  1  1 = max, 0 = min
in_numA  input  DATA_WIDTH  operand A
in_numB  input  DATA_WIDTH  operand B
in_tag  input  TAG_WIDTH  opaque ID, returned unchanged
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
out_num  output  DATA_WIDTH  selected result
out_tag  output  TAG_WIDTH  tag of out_num
out_nv  output  1  invalid-operation flag (see Optional Feature)

Behaviour:
- Two register stages. S1 registers the operands, op, tag, per-operand class (zero, qNaN, sNaN, normal/subnormal, inf) and the ordered-magnitude compare result. S2 registers the selected result. Latency is 2 cycles from the accepting edge (in_valid && in_ready) to out_valid; throughput is 1 per cycle.
- Stall rule: S2 advances when !s2_valid || out_ready. S1 advances when !s1_valid || S2 advances. in_ready = S1 advances && !in_rst (combinational). No bubbles under continuous out_ready=1. Held outputs stay stable while out_valid && !out_ready.
- Ordering: non-NaN operands are ordered by a total key. Positive values use the magnitude bits; negative values use their inverted magnitude; the sign is inverted as the MSB. This gives -0 < +0 and -inf < finite < +inf. Subnormals need no special case.
- Selection:
  - Neither operand NaN: return the min/max by key. Identical keys return A.
  - Exactly one NaN (quiet or signalling): return the other operand.
  - Both NaN: return canonical qNaN (sign 0, exponent all ones, fraction MSB 1, rest 0).
- Reset: s1_valid, s2_valid, out_valid, out_num, out_tag and out_nv all clear to 0 in the same cycle. in_ready is 0 while in_rst is high and 1 on the first cycle after. Reset mid-operation discards in-flight operations with no partial output. Data registers other than the outputs need no reset.
- Simultaneous accept and drain in the same cycle is legal at both stages.

Optional Feature:
- Macro: FP_MINMAX_NV_FLAG_EN.
- Defined: out_nv=1 alongside out_num when either operand is a sNaN, even if the result is the other operand. Otherwise 0. The flag is registered through S1/S2 with the result.
- Undefined: out_nv is tied to 0 and no flag logic is generated.

Decomposition:
- Package fp_unit_pkg holds:
  - class encoding constants (CLS_ZERO, CLS_SUB, CLS_NORM, CLS_INF, CLS_QNAN, CLS_SNAN)
  - MINMAX op constants (OP_MIN=0, OP_MAX=1)
  - a canonical-NaN constant function parameterised by EXP_WIDTH/MAN_WIDTH
- One sub-module, fp_classify: combinational; takes one operand and returns its class plus its ordered key. Instantiated twice in front of S1.

Test Plan:
- Max, A=0x3FF0000000000000 (1.0), B=0xC000000000000000 (-2.0), out_ready=1 -> out_num=0x3FF0000000000000, out_valid exactly 2 cycles after accept, out_nv=0.
- Min of -0 and +0 (A=0x0000000000000000, B=0x8000000000000000) -> 0x8000000000000000; Max of the same -> 0x0000000000000000.
- Min, A=0x7FF4000000000000 (sNaN), B=0x4008000000000000 (3.0) -> 0x4008000000000000, out_nv=1 with macro defined and 0 without. Both operands qNaN 0xFFF8000000000001 -> 0x7FF8000000000000.
- Back-to-back: 8 ops with tags 0..7, out_ready=1 -> 8 results on consecutive cycles, tags in order. Then hold out_ready=0 for 3 cycles mid-stream -> in_ready drops once both stages are full, no loss or duplication, out_num stable while stalled.
- Assert in_rst for 1 cycle with both stages valid -> out_valid=0 and out_num=0 next cycle; the next accepted op returns correctly after 2 cycles.
- EXP_WIDTH=8, MAN_WIDTH=23: Max of A=0x7F800000 (+inf) and B=0x7F7FFFFF -> 0x7F800000; Min of 0x00000001 (subnormal) and 0x80000001 -> 0x80000001.
